// File: rtl/sched_pkg.sv
// Shared opcode constants, instruction field positions and class-decode helpers
// used by the dual-issue scheduler and the control unit.
package sched_pkg;

   localparam int INSTR_BITS = 16;
   localparam int FIELD_W    = 4;
   localparam int OPC_LSB    = 12;
   localparam int RD_LSB     = 8;
   localparam int RS1_LSB    = 4;
   localparam int RS2_LSB    = 0;

   typedef logic [FIELD_W-1:0] opcode_t;

   localparam opcode_t OP_NOP = 4'b0000;
   localparam opcode_t OP_ADD = 4'b0001;
   localparam opcode_t OP_SUB = 4'b0010;
   localparam opcode_t OP_MUL = 4'b0011;
   localparam opcode_t OP_LD  = 4'b0100;
   localparam opcode_t OP_ST  = 4'b0101;
   localparam opcode_t OP_CMP = 4'b0110;
   localparam opcode_t OP_MOV = 4'b0111;
   localparam opcode_t OP_OR  = 4'b1000;
   localparam opcode_t OP_AND = 4'b1001;
   localparam opcode_t OP_NOT = 4'b1010;
   localparam opcode_t OP_LSL = 4'b1011;
   localparam opcode_t OP_UBR = 4'b1100;
   localparam opcode_t OP_LSR = 4'b1101;
   localparam opcode_t OP_BEQ = 4'b1110;
   localparam opcode_t OP_BGT = 4'b1111;

   function automatic opcode_t opc(input logic [INSTR_BITS-1:0] instr);
      return instr[OPC_LSB +: FIELD_W];
   endfunction

   function automatic logic [FIELD_W-1:0] rd_of(input logic [INSTR_BITS-1:0] instr);
      return instr[RD_LSB +: FIELD_W];
   endfunction

   function automatic logic writes_rd(input logic [INSTR_BITS-1:0] instr);
      return opc(instr) inside {OP_ADD, OP_SUB, OP_MUL, OP_LD, OP_MOV,
                                OP_OR, OP_AND, OP_NOT, OP_LSL, OP_LSR};
   endfunction

   // True when instr reads register r; ST also reads its rd field as store data.
   function automatic logic reads_reg(input logic [INSTR_BITS-1:0] instr,
                                      input logic [FIELD_W-1:0] r);
      opcode_t op;
      op = opc(instr);
      if (op inside {OP_NOP, OP_UBR, OP_BEQ, OP_BGT}) return 1'b0;
      return (instr[RS1_LSB +: FIELD_W] == r) || (instr[RS2_LSB +: FIELD_W] == r) ||
             ((op == OP_ST) && (rd_of(instr) == r));
   endfunction

   function automatic logic is_mem(input logic [INSTR_BITS-1:0] instr);
      return opc(instr) inside {OP_LD, OP_ST};
   endfunction

   function automatic logic is_branch(input logic [INSTR_BITS-1:0] instr);
      return opc(instr) inside {OP_UBR, OP_BEQ, OP_BGT};
   endfunction

   function automatic logic sets_flags(input logic [INSTR_BITS-1:0] instr);
      return opc(instr) == OP_CMP;
   endfunction

   function automatic logic uses_flags(input logic [INSTR_BITS-1:0] instr);
      return opc(instr) inside {OP_BEQ, OP_BGT};
   endfunction

endpackage

// File: rtl/sched_queue.sv
// Circular instruction buffer: up to two pushes and up to two pops per cycle,
// exposing the two oldest entries combinationally.
module sched_queue
   import sched_pkg::*;
#(
   parameter int QDEPTH  = 4,
   parameter int INSTR_W = 16,
   localparam int PTR_W  = $clog2(QDEPTH),
   localparam int CNT_W  = $clog2(QDEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [1:0]         push_cnt,
   input  logic [INSTR_W-1:0] push_data0,
   input  logic [INSTR_W-1:0] push_data1,
   input  logic [1:0]         pop_cnt,
   output logic [INSTR_W-1:0] head0,
   output logic [INSTR_W-1:0] head1,
   output logic [CNT_W-1:0]   count
);

   logic [INSTR_W-1:0] mem [QDEPTH];
   logic [PTR_W-1:0]   head_ptr;
   logic [PTR_W-1:0]   tail_ptr;

   assign head0 = mem[head_ptr];
   assign head1 = mem[head_ptr + PTR_W'(1)];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         head_ptr <= head_ptr + PTR_W'(pop_cnt);
         tail_ptr <= tail_ptr + PTR_W'(push_cnt);
         count    <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
      end
   end

   // Storage is not reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_cnt != 2'd0) mem[tail_ptr] <= push_data0;
      if (push_cnt == 2'd2) mem[tail_ptr + PTR_W'(1)] <= push_data1;
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: queues fetched instructions and issues up to
// two per cycle after structural, dependency and branch checks.
module dual_issue_scheduler
   import sched_pkg::*;
#(
   parameter int QDEPTH  = 4,
   parameter int MUL_LAT = 3,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic [1:0]         in_valid,
   input  logic [INSTR_W-1:0] in_instr0,
   input  logic [INSTR_W-1:0] in_instr1,
   output logic               in_ready,
   output logic [1:0]         iss_valid,
   output logic [INSTR_W-1:0] iss_instr0,
   output logic [INSTR_W-1:0] iss_instr1,
   output logic               mul_busy,
   output logic [2:0]         q_count
);

   logic [INSTR_W-1:0] h0;
   logic [INSTR_W-1:0] h1;
   logic [1:0]         push_cnt;
   logic [1:0]         pop_cnt;
   logic [2:0]         mul_cnt;
   logic               h0_mul;
   logic               h1_mul;
   logic               pair_ok;
   logic               issue0;
   logic               issue1;

   sched_queue #(.QDEPTH(QDEPTH), .INSTR_W(INSTR_W)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push_cnt   (push_cnt),
      .push_data0 (in_instr0),
      .push_data1 (in_instr1),
      .pop_cnt    (pop_cnt),
      .head0      (h0),
      .head1      (h1),
      .count      (q_count)
   );

   // Readiness comes from registered occupancy only, never from this cycle's pop.
   assign in_ready = (q_count <= 3'(QDEPTH - 2));
   assign mul_busy = (mul_cnt != 3'd0);

   always_comb begin
      push_cnt = 2'd0;
      if (in_ready && in_valid[0] && !flush) push_cnt = in_valid[1] ? 2'd2 : 2'd1;
   end

   assign h0_mul = (opc(h0) == OP_MUL);
   assign h1_mul = (opc(h1) == OP_MUL);

   assign issue0 = !stall && !flush && (q_count != 3'd0) && !(h0_mul && mul_busy);

   // Lane 1 also respects a busy multiplier so a younger MUL cannot slip in early.
   assign pair_ok = !is_branch(h0) && !is_branch(h1) &&
                    !(h0_mul && h1_mul) &&
                    !(h1_mul && mul_busy) &&
                    !(is_mem(h0) && is_mem(h1)) &&
                    !(writes_rd(h0) && reads_reg(h1, rd_of(h0))) &&
                    !(writes_rd(h0) && writes_rd(h1) && (rd_of(h0) == rd_of(h1))) &&
                    !(sets_flags(h0) && uses_flags(h1));

   assign issue1  = issue0 && (q_count >= 3'd2) && pair_ok;
   assign pop_cnt = issue0 ? (issue1 ? 2'd2 : 2'd1) : 2'd0;

   // The multiplier keeps counting through stall and flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_cnt <= 3'd0;
      end else if ((issue0 && h0_mul) || (issue1 && h1_mul)) begin
         mul_cnt <= 3'(MUL_LAT);
      end else if (mul_cnt != 3'd0) begin
         mul_cnt <= mul_cnt - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         iss_valid  <= 2'b00;
         iss_instr0 <= '0;
         iss_instr1 <= '0;
      end else begin
         iss_valid  <= {issue1, issue0};
         iss_instr0 <= issue0 ? h0 : '0;
         iss_instr1 <= issue1 ? h1 : '0;
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: pairing rules, MUL latency,
// stall/flush, pointer wrap and mid-stream reset.
module tb_dual_issue_scheduler;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [1:0]  in_valid;
   logic [15:0] in_instr0, in_instr1;
   logic        in_ready;
   logic [1:0]  iss_valid;
   logic [15:0] iss_instr0, iss_instr1;
   logic        mul_busy;
   logic [2:0]  q_count;

   int tests  = 0;
   int failed = 0;

   dual_issue_scheduler #(.QDEPTH(4), .MUL_LAT(3), .INSTR_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_instr0  (in_instr0),
      .in_instr1  (in_instr1),
      .in_ready   (in_ready),
      .iss_valid  (iss_valid),
      .iss_instr0 (iss_instr0),
      .iss_instr1 (iss_instr1),
      .mul_busy   (mul_busy),
      .q_count    (q_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic enq2(input logic [15:0] a, input logic [15:0] b);
      in_valid = 2'b11; in_instr0 = a; in_instr1 = b;
      tick();
      in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0;
      tick(); tick();
      reset = 1'b0;
      if (q_count !== 3'd0) begin failed++; $display("FAIL reset_qcount got=%0d exp=0", q_count); end
      tests++;
      if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      tests++;
      if (iss_valid !== 2'b00) begin failed++; $display("FAIL reset_valid got=%b exp=00", iss_valid); end
      tests++;
      if (iss_instr0 !== 16'h0 || iss_instr1 !== 16'h0) begin
         failed++; $display("FAIL reset_instr got=%h/%h exp=0000/0000", iss_instr0, iss_instr1);
      end
      tests++;
      if (mul_busy !== 1'b0) begin failed++; $display("FAIL reset_mulbusy got=%b exp=0", mul_busy); end
      tests++;
   endtask

   task automatic test_independent_pair();
      do_reset();
      enq2(16'h1123, 16'h8456);
      if (q_count !== 3'd2) begin failed++; $display("FAIL indep_enq_q got=%0d exp=2", q_count); end
      tests++;
      tick();
      if (iss_valid !== 2'b11 || iss_instr0 !== 16'h1123 || iss_instr1 !== 16'h8456) begin
         failed++;
         $display("FAIL indep_issue got=%b %h %h exp=11 1123 8456", iss_valid, iss_instr0, iss_instr1);
      end
      tests++;
      if (q_count !== 3'd0) begin failed++; $display("FAIL indep_q got=%0d exp=0", q_count); end
      tests++;
   endtask

   task automatic test_raw();
      do_reset();
      enq2(16'h1123, 16'h2514);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h1123 || iss_instr1 !== 16'h0000 || q_count !== 3'd1) begin
         failed++;
         $display("FAIL raw_first got=%b %h %h q=%0d exp=01 1123 0000 q=1", iss_valid, iss_instr0, iss_instr1, q_count);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h2514) begin
         failed++; $display("FAIL raw_second got=%b %h exp=01 2514", iss_valid, iss_instr0);
      end
      tests++;
      // WAW: ADD r1 then MOV r1 must split as well.
      do_reset();
      enq2(16'h1123, 16'h7170);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h1123) begin
         failed++; $display("FAIL waw_first got=%b %h exp=01 1123", iss_valid, iss_instr0);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h7170) begin
         failed++; $display("FAIL waw_second got=%b %h exp=01 7170", iss_valid, iss_instr0);
      end
      tests++;
   endtask

   task automatic test_structural();
      do_reset();
      enq2(16'h3123, 16'h3456);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h3123 || mul_busy !== 1'b1) begin
         failed++; $display("FAIL mul_first got=%b %h busy=%b exp=01 3123 busy=1", iss_valid, iss_instr0, mul_busy);
      end
      tests++;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (iss_valid !== 2'b00 || mul_busy !== 1'b1) begin
            failed++; $display("FAIL mul_hold%0d got=%b busy=%b exp=00 busy=1", i, iss_valid, mul_busy);
         end
         tests++;
      end
      tick();
      if (iss_valid !== 2'b00 || mul_busy !== 1'b0) begin
         failed++; $display("FAIL mul_drain got=%b busy=%b exp=00 busy=0", iss_valid, mul_busy);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h3456 || mul_busy !== 1'b1) begin
         failed++; $display("FAIL mul_second got=%b %h busy=%b exp=01 3456 busy=1", iss_valid, iss_instr0, mul_busy);
      end
      tests++;
      do_reset();
      enq2(16'h4123, 16'h5456);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h4123) begin
         failed++; $display("FAIL mem_first got=%b %h exp=01 4123", iss_valid, iss_instr0);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h5456) begin
         failed++; $display("FAIL mem_second got=%b %h exp=01 5456", iss_valid, iss_instr0);
      end
      tests++;
   endtask

   task automatic test_branch();
      do_reset();
      enq2(16'h6012, 16'hE000);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h6012) begin
         failed++; $display("FAIL flag_first got=%b %h exp=01 6012", iss_valid, iss_instr0);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'hE000) begin
         failed++; $display("FAIL flag_second got=%b %h exp=01 e000", iss_valid, iss_instr0);
      end
      tests++;
      do_reset();
      enq2(16'hC000, 16'h1123);
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'hC000 || iss_instr1 !== 16'h0000) begin
         failed++; $display("FAIL ubr_alone got=%b %h %h exp=01 c000 0000", iss_valid, iss_instr0, iss_instr1);
      end
      tests++;
      tick();
      if (iss_valid !== 2'b01 || iss_instr0 !== 16'h1123) begin
         failed++; $display("FAIL ubr_next got=%b %h exp=01 1123", iss_valid, iss_instr0);
      end
      tests++;
   endtask

   task automatic test_stall_flush();
      do_reset();
      stall = 1'b1;
      enq2(16'h1123, 16'h8456);
      if (q_count !== 3'd2 || in_ready !== 1'b1) begin
         failed++; $display("FAIL fill_half got q=%0d rdy=%b exp q=2 rdy=1", q_count, in_ready);
      end
      tests++;
      enq2(16'h1E77, 16'h8F77);
      if (q_count !== 3'd4 || in_ready !== 1'b0) begin
         failed++; $display("FAIL fill_full got q=%0d rdy=%b exp q=4 rdy=0", q_count, in_ready);
      end
      tests++;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (iss_valid !== 2'b00 || q_count !== 3'd4) begin
            failed++; $display("FAIL stall_hold%0d got=%b q=%0d exp=00 q=4", i, iss_valid, q_count);
         end
         tests++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      if (q_count !== 3'd0 || in_ready !== 1'b1 || iss_valid !== 2'b00) begin
         failed++; $display("FAIL flush got q=%0d rdy=%b v=%b exp q=0 rdy=1 v=00", q_count, in_ready, iss_valid);
      end
      tests++;
      flush = 1'b1;
      enq2(16'h1123, 16'h8456);
      flush = 1'b0;
      if (q_count !== 3'd0) begin failed++; $display("FAIL flush_drop_enq got q=%0d exp q=0", q_count); end
      tests++;
      tick();
      if (iss_valid !== 2'b00) begin failed++; $display("FAIL flush_no_issue got=%b exp=00", iss_valid); end
      tests++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] e0, e1;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         if (c < 10) begin
            in_valid  = 2'b11;
            in_instr0 = {4'h1, 4'hE, 4'(c), 4'(c)};
            in_instr1 = {4'h8, 4'hF, 4'(c), 4'(c)};
         end else begin
            in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0;
         end
         tick();
         if (c >= 1) begin
            e0 = {4'h1, 4'hE, 4'(c - 1), 4'(c - 1)};
            e1 = {4'h8, 4'hF, 4'(c - 1), 4'(c - 1)};
            if (iss_valid !== 2'b11 || iss_instr0 !== e0 || iss_instr1 !== e1) begin
               failed++;
               $display("FAIL stream_pair%0d got=%b %h %h exp=11 %h %h", c - 1, iss_valid, iss_instr0, iss_instr1, e0, e1);
            end
            tests++;
         end
      end
      if (q_count !== 3'd0) begin failed++; $display("FAIL stream_empty got q=%0d exp=0", q_count); end
      tests++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      in_valid = 2'b11; in_instr0 = 16'h3123; in_instr1 = 16'h1456;
      tick();
      tick();
      if (iss_valid !== 2'b11 || mul_busy !== 1'b1 || q_count !== 3'd2) begin
         failed++; $display("FAIL pre_reset got=%b busy=%b q=%0d exp=11 busy=1 q=2", iss_valid, mul_busy, q_count);
      end
      tests++;
      reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 2'b00;
      if (q_count !== 3'd0 || in_ready !== 1'b1 || iss_valid !== 2'b00 ||
          iss_instr0 !== 16'h0 || iss_instr1 !== 16'h0 || mul_busy !== 1'b0) begin
         failed++;
         $display("FAIL mid_reset got q=%0d rdy=%b v=%b %h %h busy=%b exp q=0 rdy=1 v=00 0000 0000 busy=0",
                  q_count, in_ready, iss_valid, iss_instr0, iss_instr1, mul_busy);
      end
      tests++;
   endtask

   initial begin
      test_reset();
      test_independent_pair();
      test_raw();
      test_structural();
      test_branch();
      test_stall_flush();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
